imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage RV32I pipeline.
- Sequences each access as a req/ack transaction. Data accesses win by default; a starvation counter guarantees fetch progress.
- The pipeline holds the PC and the IF/ID register while i_req is high and i_ack is low. It holds the MEM and earlier stages while d_req is high and d_ack is low.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; the next grant goes to fetch (range 1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- i_req  in  1  fetch request; held high until i_ack
- i_addr  in  AW  fetch address; stable while i_req is high
- i_rdata  out  DW  fetched instruction; valid only while i_ack is high
- i_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid only while d_ack is high
- d_ack  out  1  one-cycle completion pulse for data
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data; valid when m_ready is high
- m_ready  in  1  memory completes the current access this cycle
- owner  out  2  00 = idle, 01 = fetch, 10 = data (debug/stall visibility)

Behaviour:
- All outputs are registered.
- Reset (rst low at an edge):
  - state = IDLE, starve_cnt = 0.
  - m_req, m_we, i_ack, d_ack = 0; owner = 00.
  - m_addr, m_wdata, i_rdata, d_rdata = 0.
  - Reset mid-transaction abandons the access. m_req is low from the next cycle, and no ack is issued for the abandoned request.
- FSM states: IDLE, BUSY_I, BUSY_D.
- Masking: in IDLE, a requester whose ack is high this cycle is treated as not requesting. This prevents re-granting a request that is being dropped.
- IDLE arbitration, at each edge:
  - Only the data request is valid: go to BUSY_D; latch d_addr, d_we, d_wdata into m_addr, m_we, m_wdata; m_req = 1; owner = 10.
  - Only the fetch request is valid: go to BUSY_I; m_addr = i_addr, m_we = 0, m_wdata = 0; m_req = 1; owner = 01.
  - Both valid and starve_cnt < STARVE_MAX: grant data; starve_cnt += 1.
  - Both valid and starve_cnt == STARVE_MAX: grant fetch.
  - Any fetch grant sets starve_cnt = 0.
  - A data grant with i_req low sets starve_cnt = 0.
  - Neither valid: stay in IDLE; m_req = 0; owner = 00.
- BUSY_x:
  - m_req, m_we, m_addr and m_wdata are held stable.
  - On an edge with m_ready = 1: return to IDLE; m_req = 0; owner = 00.
  - On the same edge, BUSY_I sets i_rdata = m_rdata and i_ack = 1.
  - On the same edge, BUSY_D sets d_rdata = m_rdata (also captured for stores; contents don't-care) and d_ack = 1.
  - m_ready low: stay in BUSY_x; no timeout.
- i_ack and d_ack are high for exactly one cycle. They are never high together and never high while m_req is high.
- Latency:
  - Request seen in cycle 0 puts m_req high in cycle 1.
  - If m_ready is high in cycle 1, ack is high in cycle 2.
  - Zero-wait memory gives 2 cycles per access. Back-to-back accesses take 3 cycles each, because of the IDLE turnaround cycle.
  - Each memory wait cycle adds 1 cycle.
- m_ready is ignored in IDLE.
- A requester dropping req before its ack is a protocol violation. Behaviour in that case is undefined, but the FSM must still return to IDLE on m_ready.
- starve_cnt is 4 bits and saturates at STARVE_MAX; it never wraps.

Test Plan:
- Reset / mid-access abort: after reset, all outputs are 0. Grant d_req with d_addr=0x100, hold m_ready=0 for 3 cycles, then pull rst low. m_req goes low the next cycle, d_ack never pulses, and owner = 00.
- Single fetch: i_req with i_addr=0x0000_0004, m_ready tied 1, m_rdata=0x0000_0013. m_req is high in cycle 1 with m_addr=0x4 and m_we=0. i_ack is high in cycle 2 with i_rdata=0x13. The requester drops i_req in cycle 3, and no second grant occurs.
- Store with wait states: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, m_ready low for 2 cycles. m_req, m_we=1, m_addr=0x200 and m_wdata=0xDEADBEEF stay stable for 3 cycles. d_ack pulses one cycle after m_ready.
- Simultaneous requests: i_req and d_req both raised in the same cycle with fresh starve_cnt. Data is served first (owner=10). Fetch is granted in the IDLE cycle after d_ack, given that d_req was dropped.
- Starvation: STARVE_MAX=4; i_req held; d_req re-raised immediately after every ack, zero-wait memory. Exactly 4 data grants occur, then 1 fetch grant, then data resumes. starve_cnt reads 0 after the fetch grant.
- Ack masking: requester keeps req high during its ack cycle. The arbiter stays in IDLE that cycle with m_req=0 and issues no duplicate transaction.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch and data
// requesters of the pipeline; data wins by default, a starvation counter forces fetch progress.
module imem_dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       i_valid;
    logic       d_valid;
    logic       grant_d;

    // A requester still seeing its own ack is dropping that request, so it must not be re-granted.
    assign i_valid = i_req & ~i_ack;
    assign d_valid = d_req & ~d_ack;
    assign grant_d = d_valid & (~i_valid | (starve_cnt < STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            owner      <= 2'b00;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        owner   <= 2'b10;
                        // Only grants that actually bypass a waiting fetch count toward starvation.
                        if (i_valid) begin
                            if (starve_cnt < STARVE_LIMIT) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else if (!i_req) begin
                            starve_cnt <= 4'd0;
                        end
                    end else if (i_valid) begin
                        state      <= BUSY_I;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= i_addr;
                        m_wdata    <= '0;
                        owner      <= 2'b01;
                        starve_cnt <= 4'd0;
                    end else begin
                        m_req <= 1'b0;
                        owner <= 2'b00;
                    end
                end
                BUSY_I: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_req   <= 1'b0;
                        owner   <= 2'b00;
                        i_rdata <= m_rdata;
                        i_ack   <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_req   <= 1'b0;
                        owner   <= 2'b00;
                        d_rdata <= m_rdata;
                        d_ack   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                    owner <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed vector table, hand-written
// reset/starvation sequences and randomized traffic against a transaction-level model.
module tb_imem_dmem_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    imem_dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .owner(owner)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the memory (0 none, 1 fetch, 2 data) and the expected outputs.
    int          mdl_owner = 0;
    int          mdl_cnt   = 0;
    logic        e_m_req = 1'b0, e_m_we = 1'b0, e_iack = 1'b0, e_dack = 1'b0;
    logic [31:0] e_maddr = '0, e_mwdata = '0, e_irdata = '0, e_drdata = '0;

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ready;
        logic [31:0] m_rdata;
        logic        e_m_req;
        logic [1:0]  e_owner;
        logic        e_i_ack;
        logic        e_d_ack;
        logic [31:0] e_m_addr;
        logic        e_m_we;
        logic [31:0] e_m_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: predict from the spec rules, then compare after the edge.
    task automatic stepCycle();
        int want_i, want_d;
        if (!rst) begin
            mdl_owner = 0; mdl_cnt = 0;
            e_m_req = 0; e_m_we = 0; e_iack = 0; e_dack = 0;
            e_maddr = '0; e_mwdata = '0; e_irdata = '0; e_drdata = '0;
        end else begin
            want_i = (i_req && !e_iack) ? 1 : 0;
            want_d = (d_req && !e_dack) ? 1 : 0;
            e_iack = 0;
            e_dack = 0;
            if (mdl_owner == 0) begin
                if (want_d == 1 && (want_i == 0 || mdl_cnt < STARVE)) begin
                    mdl_owner = 2; e_m_req = 1;
                    e_m_we = d_we; e_maddr = d_addr; e_mwdata = d_wdata;
                    if (want_i == 1) mdl_cnt = (mdl_cnt + 1 > STARVE) ? STARVE : mdl_cnt + 1;
                    else if (!i_req) mdl_cnt = 0;
                end else if (want_i == 1) begin
                    mdl_owner = 1; e_m_req = 1;
                    e_m_we = 0; e_maddr = i_addr; e_mwdata = '0;
                    mdl_cnt = 0;
                end else begin
                    e_m_req = 0;
                end
            end else if (m_ready) begin
                if (mdl_owner == 1) begin e_irdata = m_rdata; e_iack = 1; end
                else begin e_drdata = m_rdata; e_dack = 1; end
                mdl_owner = 0;
                e_m_req = 0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("mdl_m_req", 32'(m_req), 32'(e_m_req));
        checkOutput("mdl_owner", 32'(owner), 32'(mdl_owner));
        checkOutput("mdl_i_ack", 32'(i_ack), 32'(e_iack));
        checkOutput("mdl_d_ack", 32'(d_ack), 32'(e_dack));
        if (e_m_req) begin
            checkOutput("mdl_m_addr", m_addr, e_maddr);
            checkOutput("mdl_m_we", 32'(m_we), 32'(e_m_we));
            checkOutput("mdl_m_wdata", m_wdata, e_mwdata);
        end
        if (e_iack) checkOutput("mdl_i_rdata", i_rdata, e_irdata);
        if (e_dack) checkOutput("mdl_d_rdata", d_rdata, e_drdata);
    endtask

    task automatic applyStimulus(input vec_t v);
        i_req   = v.i_req;   i_addr  = v.i_addr;
        d_req   = v.d_req;   d_we    = v.d_we;
        d_addr  = v.d_addr;  d_wdata = v.d_wdata;
        m_ready = v.m_ready; m_rdata = v.m_rdata;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int data_before;
        bit fetch_seen;
        bit resumed;

        // Row layout: inputs applied before an edge, then outputs expected after it.
        vecs[0]  = '{1, 32'h4,   0, 0, 32'h0,   32'h0,        1, 32'h13,       1, 2'b01, 0, 0, 32'h4,   0, 32'h0,        32'h0};
        vecs[1]  = '{1, 32'h4,   0, 0, 32'h0,   32'h0,        1, 32'h13,       0, 2'b00, 1, 0, 32'h0,   0, 32'h0,        32'h13};
        vecs[2]  = '{1, 32'h4,   0, 0, 32'h0,   32'h0,        1, 32'h13,       0, 2'b00, 0, 0, 32'h0,   0, 32'h0,        32'h0};
        vecs[3]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h13,       0, 2'b00, 0, 0, 32'h0,   0, 32'h0,        32'h0};
        vecs[4]  = '{0, 32'h0,   1, 1, 32'h200, 32'hDEADBEEF, 0, 32'h0,        1, 2'b10, 0, 0, 32'h200, 1, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{0, 32'h0,   1, 1, 32'h200, 32'hDEADBEEF, 0, 32'h0,        1, 2'b10, 0, 0, 32'h200, 1, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{0, 32'h0,   1, 1, 32'h200, 32'hDEADBEEF, 0, 32'h0,        1, 2'b10, 0, 0, 32'h200, 1, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{0, 32'h0,   1, 1, 32'h200, 32'hDEADBEEF, 1, 32'h5555AAAA, 0, 2'b00, 0, 1, 32'h0,   0, 32'h0,        32'h5555AAAA};
        vecs[8]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 2'b00, 0, 0, 32'h0,   0, 32'h0,        32'h0};
        vecs[9]  = '{1, 32'h40,  1, 0, 32'h300, 32'h0,        1, 32'h11,       1, 2'b10, 0, 0, 32'h300, 0, 32'h0,        32'h0};
        vecs[10] = '{1, 32'h40,  1, 0, 32'h300, 32'h0,        1, 32'h11,       0, 2'b00, 0, 1, 32'h0,   0, 32'h0,        32'h11};
        vecs[11] = '{1, 32'h40,  0, 0, 32'h0,   32'h0,        1, 32'h22,       1, 2'b01, 0, 0, 32'h40,  0, 32'h0,        32'h0};
        vecs[12] = '{1, 32'h40,  0, 0, 32'h0,   32'h0,        1, 32'h22,       0, 2'b00, 1, 0, 32'h0,   0, 32'h0,        32'h22};
        vecs[13] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 2'b00, 0, 0, 32'h0,   0, 32'h0,        32'h0};
        vecs[14] = '{0, 32'h0,   1, 0, 32'h400, 32'h0,        1, 32'h33,       1, 2'b10, 0, 0, 32'h400, 0, 32'h0,        32'h0};
        vecs[15] = '{0, 32'h0,   1, 0, 32'h400, 32'h0,        1, 32'h33,       0, 2'b00, 0, 1, 32'h0,   0, 32'h0,        32'h33};
        vecs[16] = '{0, 32'h0,   1, 0, 32'h400, 32'h0,        1, 32'h33,       0, 2'b00, 0, 0, 32'h0,   0, 32'h0,        32'h0};
        vecs[17] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 2'b00, 0, 0, 32'h0,   0, 32'h0,        32'h0};

        rst = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_ready = 0; m_rdata = '0;
        stepCycle();
        stepCycle();
        checkOutput("rst_m_req", 32'(m_req), 32'd0);
        checkOutput("rst_m_we", 32'(m_we), 32'd0);
        checkOutput("rst_i_ack", 32'(i_ack), 32'd0);
        checkOutput("rst_d_ack", 32'(d_ack), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_m_addr", m_addr, 32'd0);
        checkOutput("rst_m_wdata", m_wdata, 32'd0);
        checkOutput("rst_i_rdata", i_rdata, 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 32'd0);

        $display("[TB] mid-access reset abort");
        rst = 1;
        stepCycle();
        d_req = 1; d_we = 0; d_addr = 32'h100; m_ready = 0;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("abort_m_req_hold", 32'(m_req), 32'd1);
            checkOutput("abort_owner_hold", 32'(owner), 32'd2);
            checkOutput("abort_m_addr", m_addr, 32'h100);
        end
        rst = 0; m_ready = 1;
        stepCycle();
        checkOutput("abort_m_req", 32'(m_req), 32'd0);
        checkOutput("abort_owner", 32'(owner), 32'd0);
        checkOutput("abort_d_ack", 32'(d_ack), 32'd0);
        rst = 1; d_req = 0;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("abort_no_ack", 32'(d_ack), 32'd0);
            checkOutput("abort_idle", 32'(m_req), 32'd0);
        end

        $display("[TB] vector table");
        for (int n = 0; n < 18; n++) begin
            applyStimulus(vecs[n]);
            stepCycle();
            checkOutput($sformatf("vec%0d_m_req", n), 32'(m_req), 32'(vecs[n].e_m_req));
            checkOutput($sformatf("vec%0d_owner", n), 32'(owner), 32'(vecs[n].e_owner));
            checkOutput($sformatf("vec%0d_i_ack", n), 32'(i_ack), 32'(vecs[n].e_i_ack));
            checkOutput($sformatf("vec%0d_d_ack", n), 32'(d_ack), 32'(vecs[n].e_d_ack));
            if (vecs[n].e_m_req) begin
                checkOutput($sformatf("vec%0d_m_addr", n), m_addr, vecs[n].e_m_addr);
                checkOutput($sformatf("vec%0d_m_we", n), 32'(m_we), 32'(vecs[n].e_m_we));
                checkOutput($sformatf("vec%0d_m_wdata", n), m_wdata, vecs[n].e_m_wdata);
            end
            if (vecs[n].e_i_ack) checkOutput($sformatf("vec%0d_i_rdata", n), i_rdata, vecs[n].e_rdata);
            if (vecs[n].e_d_ack) checkOutput($sformatf("vec%0d_d_rdata", n), d_rdata, vecs[n].e_rdata);
        end

        // Fetch waits throughout but steps aside during each data ack cycle, so the
        // data requester keeps winning contested turns until the starvation limit.
        $display("[TB] starvation sequence");
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h500; d_wdata = '0;
        m_ready = 1; m_rdata = 32'h77;
        data_before = 0; fetch_seen = 0; resumed = 0;
        for (int c = 0; c < 80 && !resumed; c++) begin
            stepCycle();
            if (owner == 2'b10) begin
                if (!fetch_seen) data_before++;
                else resumed = 1;
            end
            if (owner == 2'b01 && !fetch_seen) begin
                fetch_seen = 1;
                checkOutput("starve_cnt_after_fetch", 32'(dut.starve_cnt), 32'd0);
            end
            if (!fetch_seen) i_req = !d_ack;
            else if (i_ack) i_req = 0;
        end
        checkOutput("starve_data_grants", 32'(data_before), 32'(STARVE));
        checkOutput("starve_fetch_granted", 32'(fetch_seen), 32'd1);
        checkOutput("starve_data_resumed", 32'(resumed), 32'd1);
        stepCycle();
        d_req = 0; i_req = 0;
        stepCycle();
        stepCycle();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            stepCycle();
            if ($urandom_range(99) == 0) begin
                rst = 0; i_req = 0; d_req = 0;
            end else begin
                rst = 1;
                if (!i_req || i_ack) begin
                    i_req  = ($urandom_range(2) == 0);
                    i_addr = 32'($urandom_range(1023)) << 2;
                end
                if (!d_req || d_ack) begin
                    d_req   = ($urandom_range(2) == 0);
                    d_we    = $urandom_range(1) == 1;
                    d_addr  = 32'($urandom_range(1023)) << 2;
                    d_wdata = $urandom;
                end
            end
            m_ready = ($urandom_range(2) != 0);
            m_rdata = $urandom;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
